// File: rtl/npc_pkg.sv
// Shared NPC leg definitions: FSM state codes, request codes and gate patterns.
// Other leg blocks reuse these so every leg drives identical gate words per state.
package npc_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ZERO  = 3'd1,
    ST_GAP_P = 3'd2,
    ST_POS   = 3'd3,
    ST_GAP_N = 3'd4,
    ST_NEG   = 3'd5,
    ST_SD_P  = 3'd6,
    ST_SD_N  = 3'd7
  } npc_state_e;

  typedef enum logic [1:0] {
    REQ_HOLD = 2'd0,
    REQ_P    = 2'd1,
    REQ_N    = 2'd2,
    REQ_O    = 2'd3
  } npc_req_e;

  // Gate word bit order is {S4,S3,S2,S1}
  localparam logic [3:0] G_OFF  = 4'b0000;
  localparam logic [3:0] G_ZERO = 4'b0110;
  localparam logic [3:0] G_S2   = 4'b0010;
  localparam logic [3:0] G_POS  = 4'b0011;
  localparam logic [3:0] G_S3   = 4'b0100;
  localparam logic [3:0] G_NEG  = 4'b1100;

  function automatic logic [3:0] gates_of(input npc_state_e s);
    logic [3:0] g;
    g = G_OFF;
    case (s)
      ST_ZERO:  g = G_ZERO;
      ST_GAP_P: g = G_S2;
      ST_POS:   g = G_POS;
      ST_GAP_N: g = G_S3;
      ST_NEG:   g = G_NEG;
      ST_SD_P:  g = G_S2;
      ST_SD_N:  g = G_S3;
      default:  g = G_OFF;
    endcase
    return g;
  endfunction

  // Dead-time gaps and a simultaneous P+N request both collapse to HOLD
  function automatic npc_req_e decode_req(input logic pos_s, input logic pos_nots,
                                          input logic neg_s, input logic neg_nots);
    logic rp, rn, ro;
    npc_req_e r;
    rp = pos_s & ~pos_nots;
    rn = neg_nots & ~neg_s;
    ro = pos_nots & neg_s;
    if (rp && rn)  r = REQ_HOLD;
    else if (rp)   r = REQ_P;
    else if (rn)   r = REQ_N;
    else if (ro)   r = REQ_O;
    else           r = REQ_HOLD;
    return r;
  endfunction

endpackage

// File: rtl/npc_dwell_timer.sv
// Loadable up-counter that saturates at a terminal value and flags when reached.
// Shared by dwell, gap and shutdown timing; the owner reloads it on each state change.
module npc_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q < term_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = (cnt_q >= term_i);

endmodule

// File: rtl/npc_leg_sequencer.sv
// Three-level NPC leg switching sequencer with dwell, gap and shutdown timing.
// Optional NPC_SEQ_ERRCNT_EN adds err_cnt, a saturating count of conflicting P/N request cycles.
//
//   state  | meaning
//   -------+----------------------------------------------------
//   IDLE   | all gates off; waits for en with no fault latched
//   ZERO   | S2+S3, output clamped to neutral
//   GAP_P  | S2 only, transition between ZERO and POS
//   POS    | S1+S2, positive output level
//   GAP_N  | S3 only, transition between ZERO and NEG
//   NEG    | S3+S4, negative output level
//   SD_P   | shutdown from positive side, S2 held for OFF_DELAY
//   SD_N   | shutdown from negative side, S3 held for OFF_DELAY
module npc_leg_sequencer
  import npc_pkg::*;
#(
  parameter int MIN_DWELL = 50,
  parameter int GAP_CYC   = 20,
  parameter int OFF_DELAY = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fault,
  input  logic       fault_clr,
  input  logic       pos_s,
  input  logic       pos_nots,
  input  logic       neg_s,
  input  logic       neg_nots,
  output logic [3:0] g,
  output logic [2:0] state,
`ifdef NPC_SEQ_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       fault_lat
);

  // Dwell counts edges already spent in state; gap/shutdown terminals give exact cycle counts
  localparam logic [CNT_W-1:0] T_DWELL = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] T_GAP   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] T_OFF   = CNT_W'(OFF_DELAY - 1);

  npc_state_e       state_q, state_d;
  logic [3:0]       g_q;
  logic             fault_lat_q;
  npc_req_e         req;
  logic             stop;
  logic             tmr_done;
  logic [CNT_W-1:0] tmr_term;

  assign req  = decode_req(pos_s, pos_nots, neg_s, neg_nots);
  assign stop = fault | ~en;

  always_comb begin
    tmr_term = T_DWELL;
    case (state_q)
      ST_GAP_P, ST_GAP_N: tmr_term = T_GAP;
      ST_SD_P, ST_SD_N:   tmr_term = T_OFF;
      default:            tmr_term = T_DWELL;
    endcase
  end

  npc_dwell_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_d != state_q),
    .load_val_i ('0),
    .term_i     (tmr_term),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en && !fault && !fault_lat_q) state_d = ST_ZERO;
      end
      ST_ZERO: begin
        if (stop)                          state_d = ST_IDLE;
        else if (tmr_done && req == REQ_P) state_d = ST_GAP_P;
        else if (tmr_done && req == REQ_N) state_d = ST_GAP_N;
      end
      ST_GAP_P: begin
        if (stop)                                state_d = ST_SD_P;
        else if (tmr_done && req != REQ_HOLD)    state_d = (req == REQ_P) ? ST_POS : ST_ZERO;
      end
      ST_POS: begin
        if (stop)                                           state_d = ST_SD_P;
        else if (tmr_done && (req == REQ_N || req == REQ_O)) state_d = ST_GAP_P;
      end
      ST_GAP_N: begin
        if (stop)                                state_d = ST_SD_N;
        else if (tmr_done && req != REQ_HOLD)    state_d = (req == REQ_N) ? ST_NEG : ST_ZERO;
      end
      ST_NEG: begin
        if (stop)                                           state_d = ST_SD_N;
        else if (tmr_done && (req == REQ_P || req == REQ_O)) state_d = ST_GAP_N;
      end
      // Shutdown runs to completion; fault or en changes do not restart it
      ST_SD_P, ST_SD_N: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      g_q         <= G_OFF;
      fault_lat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= gates_of(state_d);
      if (fault)                                fault_lat_q <= 1'b1;
      else if (fault_clr && state_q == ST_IDLE) fault_lat_q <= 1'b0;
    end
  end

`ifdef NPC_SEQ_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (fault_clr) begin
      err_cnt_q <= 8'd0;
    end else if (pos_s && neg_nots && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign g         = g_q;
  assign state     = state_q;
  assign fault_lat = fault_lat_q;

endmodule

// File: tb/tb_npc_leg_sequencer.sv
// Directed table-driven bench for npc_leg_sequencer with default timing parameters.
module tb_npc_leg_sequencer;
  import npc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, fault = 1'b0, fault_clr = 1'b0;
  logic       pos_s = 1'b0, pos_nots = 1'b0, neg_s = 1'b0, neg_nots = 1'b0;
  logic [3:0] g;
  logic [2:0] state;
  logic       fault_lat;
`ifdef NPC_SEQ_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit ovl_on = 1'b0;

  npc_leg_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fault     (fault),
    .fault_clr (fault_clr),
    .pos_s     (pos_s),
    .pos_nots  (pos_nots),
    .neg_s     (neg_s),
    .neg_nots  (neg_nots),
    .g         (g),
    .state     (state),
`ifdef NPC_SEQ_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .fault_lat (fault_lat)
  );

  always #5 clk = ~clk;

  // {pos_s,pos_nots,neg_s,neg_nots}
  localparam logic [3:0] RP = 4'b1010;
  localparam logic [3:0] RN = 4'b0101;
  localparam logic [3:0] RO = 4'b0110;
  localparam logic [3:0] RH = 4'b0010;
  localparam logic [3:0] RE = 4'b1001;

  typedef struct {
    logic       en;
    logic       fault;
    logic       clr;
    logic [3:0] req;
    int         n;
    logic [2:0] st;
    logic [3:0] g;
    logic       lat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic e, logic f, logic c, logic [3:0] r, int n,
                              npc_state_e s, logic [3:0] gg, logic l);
    vec_t v;
    v.en = e; v.fault = f; v.clr = c; v.req = r; v.n = n;
    v.st = s; v.g = gg; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic c, input logic [3:0] r);
    en = e; fault = f; fault_clr = c;
    pos_s = r[3]; pos_nots = r[2]; neg_s = r[1]; neg_nots = r[0];
  endtask

  // Forbidden gate overlaps checked on every falling edge
  always @(negedge clk) begin
    if (ovl_on) begin
      n_chk++;
      if ((g[0] & g[2]) | (g[1] & g[3]) | (g[0] & g[3])) begin
        n_err++;
        $display("FAIL overlap: got g=%b required no S1&S3/S2&S4/S1&S4", g);
      end
    end
  end

  initial begin
    // Normal run, dwell/gap boundaries, fault shutdown, latch clear, en-low shutdowns
    vt.push_back(mk(0,0,0,RO, 2, ST_IDLE , G_OFF , 0));
    vt.push_back(mk(1,0,0,RO, 1, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RO,10, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RP,40, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RP, 1, ST_GAP_P, G_S2  , 0));
    vt.push_back(mk(1,0,0,RP,19, ST_GAP_P, G_S2  , 0));
    vt.push_back(mk(1,0,0,RP, 1, ST_POS  , G_POS , 0));
    vt.push_back(mk(1,0,0,RN,49, ST_POS  , G_POS , 0));
    vt.push_back(mk(1,0,0,RN, 1, ST_POS  , G_POS , 0));
    vt.push_back(mk(1,0,0,RN, 1, ST_GAP_P, G_S2  , 0));
    vt.push_back(mk(1,0,0,RN,19, ST_GAP_P, G_S2  , 0));
    vt.push_back(mk(1,0,0,RN, 1, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RN,50, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RN, 1, ST_GAP_N, G_S3  , 0));
    vt.push_back(mk(1,0,0,RH,30, ST_GAP_N, G_S3  , 0));
    vt.push_back(mk(1,0,0,RN, 1, ST_NEG  , G_NEG , 0));
    vt.push_back(mk(1,0,0,RH,60, ST_NEG  , G_NEG , 0));
    vt.push_back(mk(1,1,0,RN, 1, ST_SD_N , G_S3  , 1));
    vt.push_back(mk(1,0,0,RN,50, ST_SD_N , G_S3  , 1));
    vt.push_back(mk(1,1,0,RN, 1, ST_SD_N , G_S3  , 1));
    vt.push_back(mk(1,0,0,RN,47, ST_SD_N , G_S3  , 1));
    vt.push_back(mk(1,0,0,RN, 1, ST_SD_N , G_S3  , 1));
    vt.push_back(mk(1,0,0,RN, 1, ST_IDLE , G_OFF , 1));
    vt.push_back(mk(1,0,0,RO, 5, ST_IDLE , G_OFF , 1));
    vt.push_back(mk(1,1,1,RO, 1, ST_IDLE , G_OFF , 1));
    vt.push_back(mk(1,0,1,RO, 1, ST_IDLE , G_OFF , 0));
    vt.push_back(mk(1,0,0,RO, 1, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(0,0,0,RO, 1, ST_IDLE , G_OFF , 0));
    vt.push_back(mk(1,0,0,RO, 1, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RP,50, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RP, 1, ST_GAP_P, G_S2  , 0));
    vt.push_back(mk(0,0,0,RP, 1, ST_SD_P , G_S2  , 0));
    vt.push_back(mk(0,0,0,RP,99, ST_SD_P , G_S2  , 0));
    vt.push_back(mk(0,0,0,RP, 1, ST_IDLE , G_OFF , 0));
    vt.push_back(mk(1,0,0,RP, 1, ST_ZERO , G_ZERO, 0));
    vt.push_back(mk(1,0,0,RP,51, ST_GAP_P, G_S2  , 0));

    drive(0, 0, 0, RO);
    tick(3);
    chk("reset state", 32'(state), 32'(ST_IDLE));
    chk("reset g", 32'(g), 32'(G_OFF));
    chk("reset fault_lat", 32'(fault_lat), 32'd0);
`ifdef NPC_SEQ_ERRCNT_EN
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    ovl_on = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].en, vt[i].fault, vt[i].clr, vt[i].req);
      tick(vt[i].n);
      chk($sformatf("row%0d state", i), 32'(state), 32'(vt[i].st));
      chk($sformatf("row%0d g", i), 32'(g), 32'(vt[i].g));
      chk($sformatf("row%0d fault_lat", i), 32'(fault_lat), 32'(vt[i].lat));
    end

    // Asynchronous reset in the middle of GAP_P, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst g", 32'(g), 32'(G_OFF));
    chk("async rst state", 32'(state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post rst state", 32'(state), 32'(ST_IDLE));
    drive(1, 0, 0, RP);
    tick(1);
    chk("recover state", 32'(state), 32'(ST_ZERO));
    chk("recover g", 32'(g), 32'(G_ZERO));

`ifdef NPC_SEQ_ERRCNT_EN
    drive(1, 0, 0, RE);
    tick(300);
    chk("errcnt sat", 32'(err_cnt), 32'd255);
    chk("errcnt state held", 32'(state), 32'(ST_ZERO));
    drive(1, 0, 1, RO);
    tick(1);
    chk("errcnt clear", 32'(err_cnt), 32'd0);
`endif

    ovl_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
